// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory, redirect and instruction-stream signals of the fetch unit
interface ifetch_if;
  logic [31:0] imem_a, imem_rd, redirect_pc, inst, inst_pc;
  logic redirect, inst_valid, inst_ready, fault;
  modport master (output imem_a, inst_valid, inst, inst_pc, fault,
                  input imem_rd, redirect, redirect_pc, inst_ready);
  modport slave (input imem_a, inst_valid, inst, inst_pc, fault,
                 output imem_rd, redirect, redirect_pc, inst_ready);
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential fetch with a 2-entry {pc, inst} buffer, redirect flush and misalign fault
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_WORDS = 64
) (
  input logic clk,
  input logic rst_n,
  ifetch_if.master f
);
  localparam logic [31:0] LIM = 32'(MEM_WORDS * 4);
  logic [31:0] pc, pc_inc, pc_next, e0_pc, e0_i, e1_pc, e1_i;
  logic [1:0] count, slot;
  logic pop, push;
  assign f.imem_a = pc;
  assign f.inst_valid = count != 2'd0;
  assign f.inst = e0_i;
  assign f.inst_pc = e0_pc;
  assign pop = f.inst_valid & f.inst_ready;
  assign push = ~f.redirect & ((count != 2'd2) | pop);
  assign slot = count - {1'b0, pop};
  assign pc_inc = pc + 32'd4;
  assign pc_next = pc_inc >= LIM ? pc_inc - LIM : pc_inc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      count <= 2'd0;
      e0_pc <= '0;
      e0_i <= '0;
      e1_pc <= '0;
      e1_i <= '0;
      f.fault <= 1'b0;
    end else begin
      f.fault <= f.redirect & (|f.redirect_pc[1:0]);
      if (f.redirect) begin
        count <= 2'd0;
        pc <= {f.redirect_pc[31:2], 2'b00} % LIM;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (push) pc <= pc_next;
        // the tail slot is computed after the pop shift, so a refill can land in e0
        if (pop) begin
          e0_pc <= e1_pc;
          e0_i <= e1_i;
        end
        if (push && slot == 2'd0) begin
          e0_pc <= pc;
          e0_i <= f.imem_rd;
        end
        if (push && slot == 2'd1) begin
          e1_pc <= pc;
          e1_i <= f.imem_rd;
        end
      end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of reset, streaming, stall, redirect, fault and wrap
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  ifetch_if f();
  ifetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(64)) dut (.clk(clk), .rst_n(rst_n), .f(f));
  always #5 clk = ~clk;
  assign f.imem_rd = 32'hA000_0000 + (f.imem_a >> 2);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    f.redirect = 1'b0;
    f.redirect_pc = '0;
    f.inst_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_valid", {31'b0, f.inst_valid}, 32'd0);
    chk("rst_imem_a", f.imem_a, 32'h0);
    chk("rst_inst", f.inst, 32'h0);
    chk("rst_inst_pc", f.inst_pc, 32'h0);
    chk("rst_fault", {31'b0, f.fault}, 32'd0);
    rst_n = 1'b1;
    tick;
    chk("s0_valid", {31'b0, f.inst_valid}, 32'd1);
    chk("s0_pc", f.inst_pc, 32'h00);
    chk("s0_inst", f.inst, 32'hA000_0000);
    tick;
    chk("s1_pc", f.inst_pc, 32'h04);
    chk("s1_inst", f.inst, 32'hA000_0001);
    tick;
    chk("s2_pc", f.inst_pc, 32'h08);
    chk("s2_inst", f.inst, 32'hA000_0002);
    rst_n = 1'b0;
    f.inst_ready = 1'b0;
    #1;
    chk("arst_valid", {31'b0, f.inst_valid}, 32'd0);
    chk("arst_inst", f.inst, 32'h0);
    chk("arst_inst_pc", f.inst_pc, 32'h0);
    chk("arst_fault", {31'b0, f.fault}, 32'd0);
    chk("arst_imem_a", f.imem_a, 32'h0);
    #1 rst_n = 1'b1;
    tick;
    chk("restart_pc", f.inst_pc, 32'h00);
    chk("restart_valid", {31'b0, f.inst_valid}, 32'd1);
    tick;
    chk("fill_imem_a", f.imem_a, 32'h08);
    tick;
    chk("stall_imem_a", f.imem_a, 32'h08);
    chk("stall_pc", f.inst_pc, 32'h00);
    chk("stall_inst", f.inst, 32'hA000_0000);
    f.inst_ready = 1'b1;
    chk("drain0_pc", f.inst_pc, 32'h00);
    tick;
    chk("drain1_pc", f.inst_pc, 32'h04);
    chk("drain1_imem_a", f.imem_a, 32'h0C);
    tick;
    chk("drain2_pc", f.inst_pc, 32'h08);
    chk("drain2_inst", f.inst, 32'hA000_0002);
    f.inst_ready = 1'b0;
    tick;
    chk("full_imem_a", f.imem_a, 32'h10);
    f.redirect = 1'b1;
    f.redirect_pc = 32'h40;
    tick;
    f.redirect = 1'b0;
    chk("rd_valid", {31'b0, f.inst_valid}, 32'd0);
    chk("rd_imem_a", f.imem_a, 32'h40);
    chk("rd_fault", {31'b0, f.fault}, 32'd0);
    tick;
    chk("rd_tgt_valid", {31'b0, f.inst_valid}, 32'd1);
    chk("rd_tgt_pc", f.inst_pc, 32'h40);
    chk("rd_tgt_inst", f.inst, 32'hA000_0010);
    f.inst_ready = 1'b1;
    f.redirect = 1'b1;
    f.redirect_pc = 32'h42;
    tick;
    f.redirect = 1'b0;
    chk("mis_fault", {31'b0, f.fault}, 32'd1);
    chk("mis_valid", {31'b0, f.inst_valid}, 32'd0);
    tick;
    chk("mis_fault_end", {31'b0, f.fault}, 32'd0);
    chk("mis_pc", f.inst_pc, 32'h40);
    f.redirect = 1'b1;
    f.redirect_pc = 32'h80;
    tick;
    f.redirect_pc = 32'h20;
    tick;
    f.redirect = 1'b0;
    chk("b2b_valid", {31'b0, f.inst_valid}, 32'd0);
    chk("b2b_imem_a", f.imem_a, 32'h20);
    tick;
    chk("b2b_pc", f.inst_pc, 32'h20);
    f.redirect = 1'b1;
    f.redirect_pc = 32'hFC;
    tick;
    f.redirect = 1'b0;
    chk("wrap_empty", {31'b0, f.inst_valid}, 32'd0);
    tick;
    chk("wrap_pc0", f.inst_pc, 32'hFC);
    chk("wrap_inst0", f.inst, 32'hA000_003F);
    tick;
    chk("wrap_pc1", f.inst_pc, 32'h00);
    chk("wrap_inst1", f.inst, 32'hA000_0000);
    tick;
    chk("wrap_pc2", f.inst_pc, 32'h04);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
